// File: rtl/mem_arbiter_rr.sv
// N-port memory arbiter: one downstream port shared by several requestors.
// Round-robin or fixed-priority selection, locked grant until mem_resp, back-to-back regrant.
module mem_arbiter_rr #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int RR_MODE    = 1,
  localparam int IDXW      = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            port_read,
  input  logic [NUM_PORTS-1:0]            port_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata,
  output logic [NUM_PORTS-1:0]            port_resp,
  output logic [DATA_WIDTH-1:0]           port_rdata,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic                            mem_resp,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic                            grant_valid,
  output logic [IDXW-1:0]                 grant_idx
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_reg;
  logic [IDXW-1:0]       grant_idx_reg;
  logic [IDXW-1:0]       rr_ptr_reg;
  logic                  busy;
  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  arb_req;
  logic                  win_found;
  logic [IDXW-1:0]       win_idx;
  logic [IDXW-1:0]       win_next;
  logic [IDXW:0]         cand;
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];

  assign busy = (state_reg == BUSY);
  assign req  = port_read | port_write;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign addr_arr[gi]  = port_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = port_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign port_resp[gi] = busy & mem_resp & (grant_idx_reg == IDXW'(gi));
    end
  endgenerate

  // The finishing port still holds its request during mem_resp, so it is masked out.
  always_comb begin
    arb_req = req;
    if (busy) arb_req[grant_idx_reg] = 1'b0;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, rr_ptr_reg} + (IDXW+1)'(i);
      if (cand >= (IDXW+1)'(NUM_PORTS)) cand = cand - (IDXW+1)'(NUM_PORTS);
      if (!win_found && arb_req[cand[IDXW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDXW-1:0];
      end
    end
  end

  assign win_next = (win_idx == IDXW'(NUM_PORTS-1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      grant_idx_reg <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            state_reg     <= BUSY;
            grant_idx_reg <= win_idx;
            if (RR_MODE != 0) rr_ptr_reg <= win_next;
          end
        end
        BUSY: begin
          if (mem_resp) begin
            if (win_found) begin
              grant_idx_reg <= win_idx;
              if (RR_MODE != 0) rr_ptr_reg <= win_next;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_read    = busy & port_read[grant_idx_reg];
  assign mem_write   = busy & port_write[grant_idx_reg];
  assign mem_addr    = busy ? addr_arr[grant_idx_reg]  : '0;
  assign mem_wdata   = busy ? wdata_arr[grant_idx_reg] : '0;
  assign port_rdata  = mem_rdata;
  assign grant_valid = busy;
  assign grant_idx   = grant_idx_reg;

endmodule
